// File: rtl/fifo_burst_reader.sv
// Read-side controller for the single-clock byte FIFO: drains threshold or
// timeout bursts and presents them as a valid/ready stream with an end-of-burst marker.
module fifo_burst_reader #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned CNT_W         = 7,
  parameter int unsigned BURST_LEN     = 16,
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              burst_active,
  output logic [15:0]       bursts_done
);

  localparam int unsigned TMO_W     = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned OCC_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     rd_issued_q;
  logic [TMO_W-1:0]     tmo_q;
  logic                 in_flight_q;
  logic                 in_flight_last_q;
  logic [DATA_W-1:0]    buf_data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_last_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]     occ_q;
  logic [15:0]          bursts_done_q;

  logic push, pop, last_hs;
  logic go_burst, go_flush, tmo_hit;
  logic room, reads_left, is_last_read;

  // Stream side is the head of the output buffer
  assign m_valid     = (occ_q != '0);
  assign m_data      = m_valid ? buf_data_q[rd_ptr_q] : '0;
  assign m_last      = m_valid & buf_last_q[rd_ptr_q];
  assign pop         = m_valid & m_ready;
  assign push        = in_flight_q;
  assign last_hs     = pop & m_last;
  assign bursts_done = bursts_done_q;

  assign go_burst     = (fifo_count >= CNT_W'(BURST_LEN));
  assign tmo_hit      = (tmo_q == TMO_W'(FLUSH_TIMEOUT));
  assign go_flush     = tmo_hit && (fifo_count != '0);
  // A read in flight already owns a buffer slot
  assign room         = (4'(occ_q) + 4'(in_flight_q)) < 4'(BUF_DEPTH);
  assign reads_left   = (rd_issued_q < len_q);
  assign is_last_read = (rd_issued_q == CNT_W'(len_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Threshold burst takes priority over a timeout flush
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go_burst)      state_d = BURST;
        else if (go_flush) state_d = FLUSH;
      end
      BURST, FLUSH: begin
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_active = 1'b0;
    fifo_rd_en   = 1'b0;
    if (state_q != IDLE) begin
      burst_active = 1'b1;
      fifo_rd_en   = !fifo_empty && reads_left && room;
    end
  end

  // Idle-with-partial-data timer; cleared before it can pass the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if ((state_q != IDLE) || (state_d != IDLE) || (fifo_count == '0) || tmo_hit) begin
      tmo_q <= '0;
    end else if (fifo_count < CNT_W'(BURST_LEN)) begin
      tmo_q <= TMO_W'(tmo_q + TMO_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      rd_issued_q <= '0;
    end else if (state_q == IDLE) begin
      rd_issued_q <= '0;
      if (go_burst)      len_q <= CNT_W'(BURST_LEN);
      else if (go_flush) len_q <= fifo_count;
    end else if (fifo_rd_en) begin
      rd_issued_q <= CNT_W'(rd_issued_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      in_flight_q      <= fifo_rd_en;
      in_flight_last_q <= fifo_rd_en && is_last_read;
    end
  end

  // Output buffer absorbs the FIFO read latency; reset drops in-flight data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      buf_last_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_data_q[i] <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= fifo_data;
        buf_last_q[wr_ptr_q] <= in_flight_last_q;
        wr_ptr_q             <= PTR_W'(wr_ptr_q + PTR_W'(1));
      end
      if (pop) rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
      unique case ({push, pop})
        2'b10:   occ_q <= OCC_W'(occ_q + OCC_W'(1));
        2'b01:   occ_q <= OCC_W'(occ_q - OCC_W'(1));
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bursts_done_q <= '0;
    else if (last_hs) bursts_done_q <= 16'(bursts_done_q + 16'd1);
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for the team's single-clock 8-bit FIFO.
- Watches the FIFO occupancy count and drains data in bursts of BURST_LEN bytes.
- If data sits below the threshold for FLUSH_TIMEOUT cycles, drains it as a short flush burst.
- Hides the FIFO's one-cycle registered read latency behind a 4-entry output buffer and presents a valid/ready byte stream with an end-of-burst marker.

Parameters:
- DATA_W, 8, byte width; matches the FIFO data port.
- CNT_W, 7, width of the FIFO occupancy count (0..64).
- BURST_LEN, 16, bytes per normal burst; legal range 2..64.
- FLUSH_TIMEOUT, 255, idle cycles with partial data before a flush burst; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_rd_en  out  1  read strobe to the FIFO; combinational.
- fifo_data  in  DATA_W  FIFO read data; valid the cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  CNT_W  FIFO occupancy.
- m_data  out  DATA_W  stream data (head of output buffer).
- m_valid  out  1  stream valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  marks the final byte of the current burst.
- burst_active  out  1  high in BURST or FLUSH state.
- bursts_done  out  16  completed-burst counter; wraps.

Behaviour:
- Reset, asynchronous:
  - state=IDLE; output buffer empty; in-flight tracker cleared.
  - Timeout counter, read counter and bursts_done = 0.
  - m_valid, m_last, burst_active, fifo_rd_en = 0; m_data = 0.
- States: IDLE, BURST, FLUSH.
- IDLE → BURST: when fifo_count ≥ BURST_LEN. Burst length latched as BURST_LEN.
- IDLE → FLUSH: when the timeout counter reaches FLUSH_TIMEOUT and fifo_count ≠ 0. Burst length latched as current fifo_count, which is 1..BURST_LEN-1.
- IDLE priority: if both conditions hold in the same cycle, BURST wins.
- Timeout counter:
  - Increments in IDLE while 0 < fifo_count < BURST_LEN.
  - Clears when fifo_count = 0, on entry to BURST or FLUSH, and when it hits FLUSH_TIMEOUT.
  - Saturates; never wraps.
- BURST/FLUSH → IDLE: on the clock edge where the byte with m_last=1 completes its handshake (m_valid & m_ready).
- Read issue: fifo_rd_en = burst_active & !fifo_empty & (reads_issued < len) & (buf_occ + in_flight < 4).
  - fifo_rd_en is never asserted while fifo_empty=1.
  - fifo_rd_en is never asserted in IDLE.
- Read latency:
  - rd_en in cycle T; fifo_data sampled at edge ending T+1; written into the output buffer.
  - m_valid can first be high in cycle T+2.
  - A read counts as in flight from cycle T until it is written into the buffer.
- Output buffer: 4-entry FIFO.
  - Pop on m_valid & m_ready. Push and pop in the same cycle are allowed.
  - Sustains 1 byte/cycle when m_ready=1 and the FIFO keeps data available.
- Stream rules:
  - m_valid, m_data and m_last hold stable until the handshake.
  - m_valid never drops without a handshake.
- m_last: tagged on the buffered entry whose read index = len-1 (that byte's rd_en cycle had reads_issued = len-1).
- bursts_done: +1 on each m_last handshake; 16-bit wrap from 0xFFFF to 0x0000.
- FIFO underrun mid-burst: if fifo_empty rises mid-burst, issue pauses and resumes when data returns. The burst is not truncated.
- Burst length is fixed at latch; later fifo_count changes do not alter it.
- Reset mid-burst: buffered and in-flight bytes are discarded. The in-flight byte still arrives on fifo_data but must not be captured.

Test Plan:
- Reset, then write 16 bytes 0x00..0x0F into the FIFO, m_ready=1 → BURST entered; first m_valid 3 cycles after fifo_count reaches 16; 16 consecutive beats 0x00..0x0F; m_last only on 0x0F; bursts_done=1; FIFO empty; state IDLE.
- Write 5 bytes 0xA0..0xA4, FLUSH_TIMEOUT=255 → no rd_en for 255 IDLE cycles; then FLUSH with 5 beats; m_last on 0xA4; bursts_done increments.
- BURST with m_ready held low 10 cycles → exactly 4 rd_en pulses; m_valid high with m_data stable; on release, remaining 12 bytes stream in order with no loss or duplication.
- Producer supplies 16 bytes at 1 byte per 3 cycles after the burst starts → rd_en never asserted with fifo_empty=1; 16 bytes delivered; single m_last.
- Assert rst in the 6th beat of a burst → all outputs 0 the same cycle; after release, the FIFO-held remainder is drained only by a new threshold or flush event.
- Preload bursts_done to 0xFFFF via 65535 bursts (or force) → next burst completion gives 0x0000.
